cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control.sv | 155 +++++++++++++++
 tb/tb_cache_control.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// Purpose: cache controller FSM for hit/miss handling, victim writeback and line refill, with optional perf counters.
// Latency: a hit answers (mem_resp) in the cycle after the request is sampled; a miss adds writeback and refill time.
// Backpressure: CPU holds mem_read/mem_write until mem_resp; pmem_read/pmem_write are held until pmem_resp.
// Optional feature: define CACHE_CONTROL_PERF_CNT_EN to build the hit/miss/writeback counters.
module cache_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 in_cache,
  input  logic                 dirty_overwrite,
  output logic                 cache_write,
  output logic                 cache_read,
  output logic                 from_processor,
  output logic                 lru_update,
  output logic                 miss_cache_read,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   req;

  // A simultaneous read and write is handled as a write; either one is a live request.
  assign req = mem_read | mem_write;

  // State register; reset returns to IDLE immediately, which also zeroes every decoded output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore/Mealy output decode.
  always_comb begin
    state_nxt       = state;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    cache_write     = 1'b0;
    cache_read      = 1'b0;
    from_processor  = 1'b0;
    lru_update      = 1'b0;
    miss_cache_read = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        cache_read = 1'b1;
        if (!req) begin
          state_nxt = IDLE;
        end else if (in_cache) begin
          mem_resp   = 1'b1;
          lru_update = 1'b1;
          if (mem_write) begin
            cache_write    = 1'b1;
            from_processor = 1'b1;
          end
          state_nxt = IDLE;
        end else begin
          miss_cache_read = 1'b1;
          state_nxt       = dirty_overwrite ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        // The victim line stays selected while memory absorbs it.
        miss_cache_read = 1'b1;
        pmem_write      = 1'b1;
        if (pmem_resp) begin
          state_nxt = req ? ALLOCATE : IDLE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          // Fill the line from memory even if the CPU gave up; the data is valid.
          cache_write = 1'b1;
          state_nxt   = req ? CHECK : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef CACHE_CONTROL_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic refill;
  logic hit_evt;
  logic miss_evt;
  logic wb_evt;

  assign hit_evt  = (state == CHECK) && req && in_cache && !refill;
  assign miss_evt = (state == CHECK) && req && !in_cache;
  assign wb_evt   = (state == WRITEBACK) && pmem_resp;

  // Refill flag marks that the current request already missed, so its final hit is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refill <= 1'b0;
    end else if (miss_evt) begin
      refill <= 1'b1;
    end else if ((state != IDLE) && (state_nxt == IDLE)) begin
      refill <= 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_evt && (hit_count != CNT_MAX)) begin
        hit_count <= hit_count + CNT_ONE;
      end
      if (miss_evt && (miss_count != CNT_MAX)) begin
        miss_count <= miss_count + CNT_ONE;
      end
      if (wb_evt && (wb_count != CNT_MAX)) begin
        wb_count <= wb_count + CNT_ONE;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Purpose: randomized self-checking bench for cache_control against a transaction-level schedule model.
// Latency: expects hit response one cycle after sampling; miss timing derived from writeback/refill lengths.
// Backpressure: bench acts as CPU (holds request until mem_resp) and as memory (pulses pmem_resp after a chosen delay).
module tb_cache_control;

`ifdef CACHE_CONTROL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          rst;
  logic          mem_read;
  logic          mem_write;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic          pmem_resp;
  logic          in_cache;
  logic          dirty_overwrite;
  logic          cache_write;
  logic          cache_read;
  logic          from_processor;
  logic          lru_update;
  logic          miss_cache_read;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] wb_count;

  int total;
  int bad;
  int m_hit;
  int m_miss;
  int m_wb;

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_resp       (pmem_resp),
    .in_cache        (in_cache),
    .dirty_overwrite (dirty_overwrite),
    .cache_write     (cache_write),
    .cache_read      (cache_read),
    .from_processor  (from_processor),
    .lru_update      (lru_update),
    .miss_cache_read (miss_cache_read),
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .wb_count        (wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bit order: mem_resp pmem_read pmem_write cache_write cache_read from_processor lru_update miss_cache_read
  function automatic logic [7:0] outs();
    return {mem_resp, pmem_read, pmem_write, cache_write,
            cache_read, from_processor, lru_update, miss_cache_read};
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [3*CW-1:0] exp_cnt();
    logic [CW-1:0] h, m, w;
    h = PERF ? CW'(m_hit)  : '0;
    m = PERF ? CW'(m_miss) : '0;
    w = PERF ? CW'(m_wb)   : '0;
    return {h, m, w};
  endfunction

  // One CPU request. wl/rl = cycles pmem_write/pmem_read stay high; drop_at > 0 drops the
  // request in that cycle (counted from the first CHECK cycle = 0).
  task automatic run_txn(input bit wr, input bit hit, input bit dirty,
                         input int wl, input int rl, input int drop_at, input string nm);
    int w;
    int t_end;
    int pm_end;
    bit dropped;
    bit is_chk, is_resp, in_wb, in_al, drop_wb;
    logic [7:0] e;
    w       = dirty ? wl : 0;
    dropped = !hit && (drop_at > 0);
    drop_wb = dropped && (drop_at <= w);
    pm_end  = drop_wb ? w : w + rl;
    t_end   = hit ? 0 : pm_end + 1;
    @(negedge clk);
    mem_write       = wr;
    mem_read        = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    in_cache        = hit;
    dirty_overwrite = dirty;
    pmem_resp       = 1'($urandom_range(0, 1));
    #1;
    total++;
    if (outs() !== 8'h00) begin
      bad++;
      $display("FAIL %s idle_accept got=%b want=%b", nm, outs(), 8'h00);
    end
    for (int t = 0; t <= t_end; t++) begin
      @(negedge clk);
      if (dropped && t == drop_at) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      in_cache = hit || (t > 0);
      is_chk   = (t == 0) || (!dropped && t == t_end);
      is_resp  = is_chk && (t == t_end);
      in_wb    = !hit && dirty && t >= 1 && t <= w;
      in_al    = !hit && !drop_wb && t > w && t <= w + rl;
      if (in_wb)      pmem_resp = (t == w);
      else if (in_al) pmem_resp = (t == w + rl);
      else            pmem_resp = 1'($urandom_range(0, 1));
      e = 8'h00;
      if (is_chk) begin
        e[3] = 1'b1;
        if (is_resp) begin
          e[7] = 1'b1;
          e[1] = 1'b1;
          e[4] = wr;
          e[2] = wr;
        end else begin
          e[0] = 1'b1;
        end
      end
      if (in_wb) begin
        e[5] = 1'b1;
        e[0] = 1'b1;
      end
      if (in_al) begin
        e[6] = 1'b1;
        e[4] = (t == w + rl);
      end
      #1;
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL %s cycle t=%0d got=%b want=%b", nm, t, outs(), e);
      end
    end
    if (hit) m_hit = sat(m_hit);
    else     m_miss = sat(m_miss);
    if (!hit && dirty) m_wb = sat(m_wb);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    #1;
    total++;
    if (outs() !== 8'h00) begin
      bad++;
      $display("FAIL %s idle_after got=%b want=%b", nm, outs(), 8'h00);
    end
    total++;
    if ({hit_count, miss_count, wb_count} !== exp_cnt()) begin
      bad++;
      $display("FAIL %s counters got=%h want=%h", nm, {hit_count, miss_count, wb_count}, exp_cnt());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_read = 1'b1;
    mem_write = 1'b0;
    in_cache = 1'b1;
    dirty_overwrite = 1'b1;
    pmem_resp = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (outs() !== 8'h00 || {hit_count, miss_count, wb_count} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%b/%h want=%b/%h", outs(),
               {hit_count, miss_count, wb_count}, 8'h00, 12'h000);
    end
    mem_read = 1'b0;
    pmem_resp = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_read = 1'b1;
    mem_write = 1'b0;
    in_cache = 1'b0;
    dirty_overwrite = 1'b0;
    pmem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (pmem_read !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid pre pmem_read got=%b want=1", pmem_read);
    end
    #2;
    rst = 1'b0;
    #1;
    m_hit = 0;
    m_miss = 0;
    m_wb = 0;
    total++;
    if (outs() !== 8'h00 || {hit_count, miss_count, wb_count} !== '0) begin
      bad++;
      $display("FAIL reset_mid async got=%b/%h want=%b/%h", outs(),
               {hit_count, miss_count, wb_count}, 8'h00, 12'h000);
    end
    in_cache = 1'b1;
    @(posedge clk);
    #2;
    total++;
    if (outs() !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid held got=%b want=%b", outs(), 8'h00);
    end
    rst = 1'b1;
    run_txn(1'b0, 1'b1, 1'b0, 0, 0, -1, "after_reset_hit");
  endtask

  task automatic test_read_hit();
    run_txn(1'b0, 1'b1, 1'b0, 0, 0, -1, "read_hit");
  endtask

  task automatic test_write_hit();
    run_txn(1'b1, 1'b1, 1'b1, 0, 0, -1, "write_hit");
  endtask

  task automatic test_clean_miss();
    run_txn(1'b0, 1'b0, 1'b0, 0, 5, -1, "clean_miss");
  endtask

  task automatic test_dirty_miss();
    run_txn(1'b0, 1'b0, 1'b1, 4, 6, -1, "dirty_miss");
  endtask

  task automatic test_drop();
    run_txn(1'b0, 1'b0, 1'b1, 3, 4, 2, "drop_in_wb");
    run_txn(1'b1, 1'b0, 1'b0, 0, 4, 3, "drop_in_alloc");
    run_txn(1'b0, 1'b0, 1'b1, 2, 3, 4, "drop_in_alloc2");
  endtask

  task automatic test_random();
    bit wr, hit, dirty;
    int wl, rl, dr;
    for (int i = 0; i < 40; i++) begin
      wr    = 1'($urandom_range(0, 1));
      hit   = 1'($urandom_range(0, 1));
      dirty = 1'($urandom_range(0, 1));
      wl    = $urandom_range(1, 5);
      rl    = $urandom_range(1, 5);
      dr    = -1;
      if (!hit && $urandom_range(0, 4) == 0) begin
        dr = $urandom_range(1, (dirty ? wl : 0) + rl);
      end
      run_txn(wr, hit, dirty, wl, rl, dr, "random");
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      run_txn(1'b0, 1'b1, 1'b0, 0, 0, -1, "sat_hit");
    end
    total++;
    if (hit_count !== (PERF ? 4'd15 : 4'd0)) begin
      bad++;
      $display("FAIL saturation hit_count got=%0d want=%0d", hit_count, PERF ? 15 : 0);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    total = 0;
    bad = 0;
    m_hit = 0;
    m_miss = 0;
    m_wb = 0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    in_cache = 1'b0;
    dirty_overwrite = 1'b0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_drop();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
